// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for data-memory port 1: CPU load/store (A) and loader/debug (B).
// Define DMEM_ARB_FIXED_PRIORITY_EN to make A win every tie instead of round-robin.
module dmem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1   // 1..4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [DATA_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [DATA_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_memWrite,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  input  logic [DATA_WIDTH-1:0] mem_readData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t     state, state_nxt;
  logic       last_grant;  // 0 = A, 1 = B; also names the owner of the in-flight access
  logic       we_q;
  logic [2:0] cnt;
  logic       sel_b;
  logic       start;

  always_comb begin
    sel_b = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    sel_b = b_req & ~a_req;
`else
    if (a_req && b_req) sel_b = ~last_grant;
    else                sel_b = b_req;
`endif
  end

  assign start = (state == IDLE) && (a_req || b_req);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (we_q || cnt == LAT) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory-side outputs are registered; the write strobe lives only in the first ACCESS cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant    <= 1'b1;
      we_q          <= 1'b0;
      cnt           <= '0;
      mem_memWrite  <= 1'b0;
      mem_address   <= '0;
      mem_writeData <= '0;
      a_rdata       <= '0;
      b_rdata       <= '0;
    end else begin
      mem_memWrite <= 1'b0;
      if (start) begin
        last_grant    <= sel_b;
        we_q          <= sel_b ? b_we    : a_we;
        mem_memWrite  <= sel_b ? b_we    : a_we;
        mem_address   <= sel_b ? b_addr  : a_addr;
        mem_writeData <= sel_b ? b_wdata : a_wdata;
        cnt           <= '0;
      end
      if (state == ACCESS && !we_q) begin
        if (cnt == LAT) begin
          if (last_grant) b_rdata <= mem_readData;
          else            a_rdata <= mem_readData;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

  assign a_ack = (state == RESP) && !last_grant;
  assign b_ack = (state == RESP) &&  last_grant;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: transaction-level model + per-cycle compare, directed vectors,
// and a second instance built with READ_LATENCY=3.
module tb_dmem_port_arbiter;
  localparam int DW = 32;
  localparam int RL = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // main instance (READ_LATENCY=1)
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [DW-1:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic a_ack, b_ack, mem_memWrite;
  logic [DW-1:0] a_rdata, b_rdata, mem_address, mem_writeData, mem_readData;

  dmem_port_arbiter #(.DATA_WIDTH(DW), .READ_LATENCY(RL)) u_dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_memWrite(mem_memWrite), .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_readData(mem_readData));

  // second instance (READ_LATENCY=3), only requester A used
  logic c_req = 0, c_we = 0, z_req = 0, z_we = 0;
  logic [DW-1:0] c_addr = 0, c_wdata = 0, z_addr = 0, z_wdata = 0;
  logic c_ack, z_ack, m3_write;
  logic [DW-1:0] c_rdata, z_rdata, m3_addr, m3_wdata, m3_rdata;

  dmem_port_arbiter #(.DATA_WIDTH(DW), .READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata), .a_ack(c_ack), .a_rdata(c_rdata),
    .b_req(z_req), .b_we(z_we), .b_addr(z_addr), .b_wdata(z_wdata), .b_ack(z_ack), .b_rdata(z_rdata),
    .mem_memWrite(m3_write), .mem_address(m3_addr), .mem_writeData(m3_wdata),
    .mem_readData(m3_rdata));

  // data memories: readData valid READ_LATENCY cycles after the address is sampled
  logic [DW-1:0] env_mem [64] = '{default: '0};
  logic [DW-1:0] rd1 = '0;
  always @(posedge clock) begin
    if (mem_memWrite) env_mem[mem_address[7:2]] <= mem_writeData;
    rd1 <= env_mem[mem_address[7:2]];
  end
  assign mem_readData = rd1;

  logic [DW-1:0] env3_mem [64] = '{default: '0};
  logic [DW-1:0] rd3 [3] = '{default: '0};
  always @(posedge clock) begin
    if (m3_write) env3_mem[m3_addr[7:2]] <= m3_wdata;
    rd3[0] <= env3_mem[m3_addr[7:2]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign m3_rdata = rd3[2];

  // Transaction-level model: a granted access owns the port for lat+2 edges
  // (lat = 1 write, RL+1 read); ack appears lat cycles after the grant edge.
  logic [DW-1:0] sb_mem [64] = '{default: '0};
  bit m_active = 0, m_who = 0, m_we = 0, m_last = 1;
  int m_t = 0, m_lat = 0;
  logic [DW-1:0] m_addr = 0, m_wdata = 0;
  logic e_mw = 0, e_aack = 0, e_back = 0;
  logic [DW-1:0] e_addr = 0, e_wdata = 0, e_ardata = 0, e_brdata = 0;
  int glog[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 0; m_t = 0; m_last = 1;
      e_mw = 0; e_aack = 0; e_back = 0;
      e_addr = 0; e_wdata = 0; e_ardata = 0; e_brdata = 0;
    end else begin
      if (m_active) begin
        m_t++;
        if (m_t == 1 && m_we) sb_mem[m_addr[7:2]] = m_wdata;
        if (m_t == m_lat && !m_we) begin
          if (m_who) e_brdata = sb_mem[m_addr[7:2]];
          else       e_ardata = sb_mem[m_addr[7:2]];
        end
        if (m_t == m_lat + 1) m_active = 0;
      end else if (a_req || b_req) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
        m_who = !a_req;
`else
        m_who = (a_req && b_req) ? !m_last : b_req;
`endif
        m_last  = m_who;
        m_we    = m_who ? b_we : a_we;
        m_addr  = m_who ? b_addr : a_addr;
        m_wdata = m_who ? b_wdata : a_wdata;
        m_lat   = m_we ? 1 : RL + 1;
        m_t     = 0;
        m_active = 1;
        glog.push_back(int'(m_who));
        e_addr  = m_addr;
        e_wdata = m_wdata;
      end
      e_mw   = m_active && m_we && m_t == 0;
      e_aack = m_active && m_t == m_lat && !m_who;
      e_back = m_active && m_t == m_lat &&  m_who;
    end
  end

  int mw_cnt = 0, aack_cnt = 0;
  always @(negedge clock) begin
    chk("mem_memWrite", {31'b0, mem_memWrite}, {31'b0, e_mw});
    chk("mem_address", mem_address, e_addr);
    chk("mem_writeData", mem_writeData, e_wdata);
    chk("a_ack", {31'b0, a_ack}, {31'b0, e_aack});
    chk("b_ack", {31'b0, b_ack}, {31'b0, e_back});
    chk("a_rdata", a_rdata, e_ardata);
    chk("b_rdata", b_rdata, e_brdata);
    if (mem_memWrite) mw_cnt++;
    if (a_ack) aack_cnt++;
  end

  // t_req = edge count when req was raised (sample edge is t_req+1); t_ack = edge where ack rose
  task automatic a_txn(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                       output int t_req, output int t_ack);
    bit got = 0;
    @(posedge clock); #1;
    a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; t_req = cyc;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (a_ack) begin got = 1; break; end
    end
    if (!got) chk("a_ack timeout", 0, 1);
    t_ack = cyc;
    @(posedge clock); #1 a_req = 0;
  endtask

  task automatic b_txn(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                       output int t_req, output int t_ack);
    bit got = 0;
    @(posedge clock); #1;
    b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; t_req = cyc;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (b_ack) begin got = 1; break; end
    end
    if (!got) chk("b_ack timeout", 0, 1);
    t_ack = cyc;
    @(posedge clock); #1 b_req = 0;
  endtask

  task automatic c_txn(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                       output int t_req, output int t_ack, output int held);
    bit got = 0;
    held = 0;
    @(posedge clock); #1;
    c_req = 1; c_we = we; c_addr = addr; c_wdata = wd; t_req = cyc;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (c_ack) begin got = 1; break; end
      if (m3_addr == addr) held++;
    end
    if (!got) chk("c_ack timeout", 0, 1);
    t_ack = cyc;
    @(posedge clock); #1 c_req = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
  endtask

  int tra, taa, trb, tab, hld, n0, acks, nb, mw0, aa0;

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("reset memWrite", {31'b0, mem_memWrite}, 0);
    chk("reset address", mem_address, 0);
    chk("reset a_rdata", a_rdata, 0);
    chk("reset b_rdata", b_rdata, 0);

    // A write then read
    mw0 = mw_cnt;
    a_txn(1, 32'h10, 32'hDEADBEEF, tra, taa);
    chk("write latency", taa - tra - 1, 1);
    chk("memWrite cycles", mw_cnt - mw0, 1);
    chk("mem[0x10]", env_mem[4], 32'hDEADBEEF);
    a_txn(0, 32'h10, 0, tra, taa);
    chk("read latency", taa - tra - 1, 2);
    chk("a_rdata 0x10", a_rdata, 32'hDEADBEEF);

    // simultaneous pair after reset: A first, B ack 3 cycles later
    do_reset();
    n0 = glog.size();
    fork
      a_txn(1, 32'h20, 32'h1, tra, taa);
      b_txn(1, 32'h24, 32'h2, trb, tab);
    join
    chk("pair1 first", glog[n0], 0);
    chk("pair1 second", glog[n0+1], 1);
    chk("pair1 ack spacing", tab - taa, 3);

    a_txn(1, 32'h34, 32'hAA, tra, taa);
    a_txn(0, 32'h34, 0, tra, taa);
    chk("a_rdata 0x34", a_rdata, 32'hAA);

    // second pair after an A grant: B first under round-robin
    n0 = glog.size();
    fork
      a_txn(1, 32'h28, 32'h3, tra, taa);
      b_txn(1, 32'h2C, 32'h4, trb, tab);
    join
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    chk("pair2 first", glog[n0], 0);
`else
    chk("pair2 first", glog[n0], 1);
`endif

    // rdata isolation
    b_txn(1, 32'h30, 32'h55, trb, tab);
    aa0 = aack_cnt;
    b_txn(0, 32'h30, 0, trb, tab);
    chk("b read latency", tab - trb - 1, 2);
    chk("b_rdata 0x30", b_rdata, 32'h55);
    chk("a_rdata held", a_rdata, 32'hAA);
    chk("no a_ack on B read", aack_cnt - aa0, 0);

    // back-to-back contention, both requesters held for 8 transactions
    n0 = glog.size();
    @(posedge clock); #1;
    a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h11;
    b_req = 1; b_we = 1; b_addr = 32'h24; b_wdata = 32'h22;
    acks = 0;
    for (int n = 0; n < 200 && acks < 8; n++) begin
      @(negedge clock);
      if (a_ack || b_ack) acks++;
    end
    chk("contention acks", acks, 8);
    @(posedge clock); #1 a_req = 0; b_req = 0;
    if (glog.size() < n0 + 8) chk("contention grants", glog.size() - n0, 8);
    else begin
      nb = 0;
      for (int i = 0; i < 8; i++) nb += glog[n0+i];
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
      chk("contention B grants", nb, 0);
`else
      chk("contention B grants", nb, 4);
      for (int i = 1; i < 8; i++) chk("contention alternate", glog[n0+i] ^ glog[n0+i-1], 1);
`endif
    end

    // reset during the write cycle
    @(posedge clock); #1;
    a_req = 1; a_we = 1; a_addr = 32'h38; a_wdata = 32'h77;
    @(posedge clock); #1;
    chk("mid-write memWrite", {31'b0, mem_memWrite}, 1);
    chk("mid-write address", mem_address, 32'h38);
    reset = 1;
    #1;
    chk("memWrite after reset", {31'b0, mem_memWrite}, 0);
    chk("a_ack after reset", {31'b0, a_ack}, 0);
    a_req = 0;
    @(posedge clock); #1 reset = 0;
    a_txn(0, 32'h38, 0, tra, taa);
    chk("aborted write not stored", a_rdata, 0);
    chk("post-reset read latency", taa - tra - 1, 2);
    a_txn(0, 32'h10, 0, tra, taa);
    chk("post-reset a_rdata", a_rdata, 32'hDEADBEEF);

    // READ_LATENCY=3 instance
    c_txn(1, 32'h40, 32'h12345678, tra, taa, hld);
    chk("rl3 write latency", taa - tra - 1, 1);
    c_txn(1, 32'h48, 32'hCAFE, tra, taa, hld);
    c_txn(0, 32'h40, 0, tra, taa, hld);
    chk("rl3 read latency", taa - tra - 1, 4);
    chk("rl3 address held", hld, 4);
    chk("rl3 rdata", c_rdata, 32'h12345678);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
